// File: rtl/ldm_pkg.sv
// Constants and state encoding shared by the LDM line buffer and the line shifter.
package ldm_pkg;

  localparam int LDM_LINES  = 16;
  localparam int LDM_LINE_W = 16;
  localparam int LDM_ADDR_W = 4;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DONE} ldm_state_e;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ldm_sclk_gen.sv
// Shift-clock divider: SCLK_DIV cycles low, SCLK_DIV cycles high, restarting low when enabled.
// bit_end strobes on the last high cycle, i.e. the edge where the next bit begins.
module ldm_sclk_gen
  import ldm_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic bit_end
);

  localparam int DW = cnt_w(SCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

  logic [DW-1:0] div_cnt_reg;
  logic          phase_reg;
  logic          wrap;

  assign wrap    = en && (div_cnt_reg == DIV_LAST);
  assign bit_end = wrap && phase_reg;
  assign sclk    = phase_reg;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt_reg <= '0;
      phase_reg   <= 1'b0;
    end else if (wrap) begin
      div_cnt_reg <= '0;
      phase_reg   <= ~phase_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ldm_line_shifter.sv
// Sweeps the LDM line buffer and shifts each line to the LED driver chain, bit[0] first.
// Define LDM_SHIFT_PARITY_EN to append an odd-parity bit after every line.
module ldm_line_shifter
  import ldm_pkg::*;
#(
  parameter int LINES    = LDM_LINES,
  parameter int ADDR_W   = LDM_ADDR_W,
  parameter int LINE_W   = LDM_LINE_W,
  parameter int SCLK_DIV = 2,
  parameter int LATCH_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] LDM_ADDR,
  input  logic [0:LINE_W-1] LDM_LINE_DATA,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              led_sclk,
  output logic              led_sdata,
  output logic              led_latch
);

`ifdef LDM_SHIFT_PARITY_EN
  localparam int NBITS = LINE_W + 1;
`else
  localparam int NBITS = LINE_W;
`endif
  localparam int BCW = $clog2(LINE_W + 1);
  localparam int LCW = cnt_w(LATCH_W);
  localparam logic [BCW-1:0]    BIT_LAST  = BCW'(NBITS - 1);
  localparam logic [LCW-1:0]    LAT_LAST  = LCW'(LATCH_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LINES - 1);

  ldm_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [NBITS-1:0]  shift_reg;
  logic [NBITS-1:0]  line_le;
  logic [BCW-1:0]    bit_cnt_reg;
  logic [LCW-1:0]    latch_cnt_reg;
  logic              overrun_reg;
  logic              bit_end;
  logic              latch_last;

  // Reorder the line so the shift register always emits bit index 0 from its LSB.
  for (genvar gi = 0; gi < LINE_W; gi++) begin : g_line
    assign line_le[gi] = LDM_LINE_DATA[gi];
  end
`ifdef LDM_SHIFT_PARITY_EN
  assign line_le[LINE_W] = ~^LDM_LINE_DATA;
`endif

  ldm_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (state_reg == SHIFT),
    .sclk    (led_sclk),
    .bit_end (bit_end)
  );

  assign latch_last = (latch_cnt_reg == LAT_LAST);
  assign LDM_ADDR   = addr_reg;
  assign overrun    = overrun_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    led_latch  = 1'b0;
    led_sdata  = 1'b0;
    case (state_reg)
      IDLE:  if (start) state_next = LOAD;
      LOAD: begin
        busy       = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        led_sdata = shift_reg[0];
        if (bit_end && (bit_cnt_reg == BIT_LAST)) state_next = LATCH;
      end
      LATCH: begin
        busy      = 1'b1;
        led_latch = 1'b1;
        if (latch_last) state_next = (addr_reg == ADDR_LAST) ? DONE : LOAD;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg      <= '0;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      latch_cnt_reg <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      overrun_reg <= start && (state_reg != IDLE);
      if (state_reg == LOAD) shift_reg <= line_le;
      else if (state_reg == SHIFT && bit_end) shift_reg <= shift_reg >> 1;

      if (state_reg != SHIFT) bit_cnt_reg <= '0;
      else if (bit_end)       bit_cnt_reg <= bit_cnt_reg + 1'b1;

      latch_cnt_reg <= (state_reg == LATCH && !latch_last) ? latch_cnt_reg + 1'b1 : '0;

      // Address only moves on the LATCH->LOAD edge and returns to 0 on frame exit.
      if (state_reg == LATCH && latch_last && addr_reg != ADDR_LAST) addr_reg <= addr_reg + 1'b1;
      else if (state_reg == DONE) addr_reg <= '0;
    end
  end

endmodule

// File: tb/tb_ldm_line_shifter.sv
// Scoreboard bench for ldm_line_shifter: default timing DUT plus a SCLK_DIV=1/LATCH_W=1 DUT.
module tb_ldm_line_shifter;

  localparam int LINES  = 16;
  localparam int LINE_W = 16;
`ifdef LDM_SHIFT_PARITY_EN
  localparam int NB = LINE_W + 1;
`else
  localparam int NB = LINE_W;
`endif
  localparam int CPL   = 1 + 2 * 2 * NB + 2;
  localparam int BUSYC = LINES * CPL + 1;
  localparam int FCPL  = 1 + 2 * 1 * NB + 1;
  localparam int FBUSY = LINES * FCPL + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start_f = 1'b0;
  always #5 clk = ~clk;

  logic [0:LINE_W-1] mem [LINES];

  logic [3:0]        addr, addr_f;
  logic [0:LINE_W-1] line_d, line_f;
  logic busy, done, overrun, sclk, sdata, latch;
  logic busy_f, done_f, overrun_f, sclk_f, sdata_f, latch_f;

  assign line_d = mem[addr];
  assign line_f = mem[addr_f];

  ldm_line_shifter u_dut (
    .clk(clk), .rst(rst), .start(start), .LDM_ADDR(addr), .LDM_LINE_DATA(line_d),
    .busy(busy), .done(done), .overrun(overrun),
    .led_sclk(sclk), .led_sdata(sdata), .led_latch(latch)
  );

  ldm_line_shifter #(.SCLK_DIV(1), .LATCH_W(1)) u_fast (
    .clk(clk), .rst(rst), .start(start_f), .LDM_ADDR(addr_f), .LDM_LINE_DATA(line_f),
    .busy(busy_f), .done(done_f), .overrun(overrun_f),
    .led_sclk(sclk_f), .led_sdata(sdata_f), .led_latch(latch_f)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, done_f_cnt = 0, overrun_cnt = 0, latch_total = 0;
  logic exp_q[$];
  int   lat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Serial order a driver should see for one line: index 0 upwards, then odd parity if enabled.
  function automatic logic [NB-1:0] ref_bits(input logic [0:LINE_W-1] line);
    logic [NB-1:0] r;
    for (int i = 0; i < LINE_W; i++) r[i] = line[i];
`ifdef LDM_SHIFT_PARITY_EN
    r[LINE_W] = ~^line;
`endif
    return r;
  endfunction

  task automatic push_frame();
    logic [NB-1:0] r;
    for (int l = 0; l < LINES; l++) begin
      r = ref_bits(mem[l]);
      for (int i = 0; i < NB; i++) exp_q.push_back(r[i]);
      lat_q.push_back(l);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit fast);
    if (fast) start_f = 1'b1; else start = 1'b1;
    step(1);
    start = 1'b0;
    start_f = 1'b0;
  endtask

  task automatic wait_done(input bit fast, input int target, input int budget);
    int n;
    n = 0;
    while (((fast ? done_f_cnt : done_cnt) < target) && n < budget) begin
      step(1);
      n++;
    end
    chk(fast ? "fast_frame_done" : "frame_done", fast ? done_f_cnt : done_cnt, target);
  endtask

  task automatic chk_idle_outputs(input string name);
    @(negedge clk);
    chk(name, {addr, busy, done, overrun, sclk, sdata, latch}, 0);
    chk({name, "_fast"}, {addr_f, busy_f, done_f, overrun_f, sclk_f, sdata_f, latch_f}, 0);
  endtask

  // Monitor for the default DUT: pops the expected bit at every sclk rise.
  initial begin
    logic p_sclk, p_sdata, p_latch, e;
    int busy_run, latch_run, last_lat, frame_lat, a;
    bit have_lat;
    p_sclk = 0; p_sdata = 0; p_latch = 0;
    busy_run = 0; latch_run = 0; last_lat = 0; frame_lat = 0; have_lat = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_sclk = 0; p_latch = 0; busy_run = 0; latch_run = 0; frame_lat = 0; have_lat = 0;
      end else begin
        busy_run = busy ? busy_run + 1 : 0;
        if (sclk && !p_sclk) begin
          if (exp_q.size() == 0) chk("sdata_unexpected_bit", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("sdata_bit", sdata, e);
          end
        end
        if (sclk && p_sclk) chk("sdata_stable_while_sclk_high", sdata, p_sdata);
        if (latch && !p_latch) begin
          latch_total++;
          frame_lat++;
          if (lat_q.size() == 0) chk("latch_unexpected", 1, 0);
          else begin
            a = lat_q.pop_front();
            chk("latch_addr", addr, a);
          end
          if (have_lat) chk("line_period", cyc - last_lat, CPL);
          last_lat = cyc;
          have_lat = 1;
        end
        if (latch) latch_run++;
        else if (p_latch) begin
          chk("latch_width", latch_run, 2);
          latch_run = 0;
        end
        if (done) begin
          done_cnt++;
          chk("busy_cycles", busy_run, BUSYC);
          chk("bits_left_at_done", exp_q.size(), 0);
          chk("latches_per_frame", frame_lat, LINES);
          frame_lat = 0;
          have_lat = 0;
        end
        if (overrun) overrun_cnt++;
        p_sclk = sclk; p_sdata = sdata; p_latch = latch;
      end
    end
  end

  // Monitor for the fast DUT: collects the bits of each line and compares them at the latch.
  initial begin
    logic f_bits[$];
    logic p_sclk, p_sdata, p_latch;
    logic [NB-1:0] r;
    int busy_run, last_rise, last_lat, latch_run, line_idx;
    bit have_lat;
    p_sclk = 0; p_sdata = 0; p_latch = 0;
    busy_run = 0; last_rise = 0; last_lat = 0; latch_run = 0; line_idx = 0; have_lat = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        f_bits.delete();
        p_sclk = 0; p_latch = 0; busy_run = 0; latch_run = 0; line_idx = 0; have_lat = 0;
      end else begin
        busy_run = busy_f ? busy_run + 1 : 0;
        if (sclk_f && !p_sclk) begin
          if (f_bits.size() > 0) chk("fast_sclk_period", cyc - last_rise, 2);
          last_rise = cyc;
          f_bits.push_back(sdata_f);
        end
        if (sclk_f && p_sclk) chk("fast_sdata_stable", sdata_f, p_sdata);
        if (latch_f && !p_latch) begin
          chk("fast_latch_addr", addr_f, line_idx);
          chk("fast_bits_per_line", f_bits.size(), NB);
          r = ref_bits(mem[addr_f]);
          for (int i = 0; i < NB && i < f_bits.size(); i++) begin
            if (f_bits[i] !== r[i]) chk("fast_sdata_bit", f_bits[i], r[i]);
          end
          f_bits.delete();
          if (have_lat) chk("fast_line_period", cyc - last_lat, FCPL);
          last_lat = cyc;
          have_lat = 1;
          line_idx++;
        end
        if (latch_f) latch_run++;
        else if (p_latch) begin
          chk("fast_latch_width", latch_run, 1);
          latch_run = 0;
        end
        if (done_f) begin
          done_f_cnt++;
          chk("fast_busy_cycles", busy_run, FBUSY);
          chk("fast_lines", line_idx, LINES);
          line_idx = 0;
          have_lat = 0;
        end
        p_sclk = sclk_f; p_sdata = sdata_f; p_latch = latch_f;
      end
    end
  end

  initial begin
    int l0;
    for (int n = 0; n < LINES; n++) mem[n] = 16'hA5A0 | 16'(n);

    // Reset and idle.
    step(3);
    rst = 1'b0;
    chk_idle_outputs("reset_outputs");
    for (int i = 0; i < 20; i++) chk_idle_outputs("idle_outputs");
    step(1);

    // Fast timing DUT, one frame of the reference pattern.
    pulse(1);
    wait_done(1, 1, FBUSY + 50);
    step(5);

    // Full frame with start re-issued at busy cycles 100 and BUSYC-1 (the DONE cycle).
    push_frame();
    pulse(0);
    step(100);
    pulse(0);
    step(BUSYC - 1 - 101);
    pulse(0);
    wait_done(0, 1, 50);
    step(20);
    chk("overrun_pulses", overrun_cnt, 2);
    chk("no_second_frame", busy, 0);
    chk("done_once", done_cnt, 1);

    // Random frame.
    for (int n = 0; n < LINES; n++) mem[n] = 16'($urandom);
    push_frame();
    pulse(0);
    wait_done(0, 2, BUSYC + 50);
    step(3);

    // Reset during line 5, bit 7, then a fresh frame.
    for (int n = 0; n < LINES; n++) mem[n] = 16'($urandom);
    push_frame();
    l0 = latch_total;
    pulse(0);
    step(5 * CPL + 1 + 7 * 4 - 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    chk_idle_outputs("midframe_reset_outputs");
    step(10);
    chk("latches_before_reset", latch_total - l0, 5);
    chk("reset_kept_idle", busy, 0);

    mem[0] = 16'h0001;
    mem[1] = 16'h0003;
    for (int n = 2; n < LINES; n++) mem[n] = 16'($urandom);
    push_frame();
    pulse(0);
    wait_done(0, 3, BUSYC + 50);
    step(5);
    chk("overrun_total", overrun_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
